// File: rtl/board_io_ctrl.sv
// Board key debouncer and LED driver sharing one millisecond-style tick timebase.
// Define BOARD_IO_LED_PWM_EN to build the PWM counter; otherwise LED mode 11 lights steadily.
`default_nettype none

module board_io_ctrl #(
    parameter int NUM_KEYS       = 3,
    parameter int NUM_LEDS       = 3,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BLINK_TICKS    = 250,
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [NUM_KEYS-1:0]   KEY_RAW,
    output logic [NUM_KEYS-1:0]   KEY_LEVEL,
    output logic [NUM_KEYS-1:0]   KEY_PRESS,
    output logic [NUM_KEYS-1:0]   KEY_RELEASE,
    input  logic [2*NUM_LEDS-1:0] LED_MODE,
    input  logic [8*NUM_LEDS-1:0] LED_DUTY,
    output logic [NUM_LEDS-1:0]   LED_OUT,
    output logic                  TICK
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int BL_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]     DB_LAST      = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [BL_W-1:0]     BLINK_LAST   = BL_W'(BLINK_TICKS - 1);
    localparam logic [NUM_KEYS-1:0] KEY_IDLE_RAW = {NUM_KEYS{KEY_ACTIVE_LOW}};
    localparam logic [NUM_LEDS-1:0] LED_POL      = {NUM_LEDS{LED_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PWM   = 2'b11
    } led_mode_e;

    // Timebase
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_q, tick_d;

    // Key path
    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [NUM_KEYS-1:0] key_pressed;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];

    // LED path
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [NUM_LEDS-1:0] led_lit;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;

    // TICK is registered: it is high while the counter sits at its last value.
    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
        tick_d     = (tick_cnt_d == TICK_LAST);
    end

    always_comb begin
        sync1_d     = KEY_RAW;
        sync2_d     = sync1_q;
        key_pressed = sync2_q ^ KEY_IDLE_RAW;
    end

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (key_pressed[k] == level_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (tick_q) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    level_d[k]   = key_pressed[k];
                    press_d[k]   = key_pressed[k];
                    release_d[k] = ~key_pressed[k];
                    db_cnt_d[k]  = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

`ifdef BOARD_IO_LED_PWM_EN
    logic [7:0] pwm_cnt_q, pwm_cnt_d;

    always_comb pwm_cnt_d = pwm_cnt_q + 8'd1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_d;
    end
`else
    logic duty_unused;
    assign duty_unused = ^LED_DUTY;
`endif

    always_comb begin
        led_lit = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (led_mode_e'(LED_MODE[2*i +: 2]))
                LED_OFF:   led_lit[i] = 1'b0;
                LED_ON:    led_lit[i] = 1'b1;
                LED_BLINK: led_lit[i] = blink_phase_q;
`ifdef BOARD_IO_LED_PWM_EN
                LED_PWM:   led_lit[i] = (pwm_cnt_q < LED_DUTY[8*i +: 8]);
`else
                LED_PWM:   led_lit[i] = 1'b1;
`endif
                default:   led_lit[i] = 1'b0;
            endcase
        end
        led_out_d = led_lit ^ LED_POL;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tick_cnt_q    <= '0;
            tick_q        <= 1'b0;
            sync1_q       <= KEY_IDLE_RAW;
            sync2_q       <= KEY_IDLE_RAW;
            level_q       <= '0;
            press_q       <= '0;
            release_q     <= '0;
            // NOTE: the per-key counter array is small control state, so it is reset like any flop.
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            led_out_q     <= LED_POL;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            tick_q        <= tick_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            level_q       <= level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_out_q     <= led_out_d;
        end
    end

    assign TICK        = tick_q;
    assign KEY_LEVEL   = level_q;
    assign KEY_PRESS   = press_q;
    assign KEY_RELEASE = release_q;
    assign LED_OUT     = led_out_q;

endmodule

`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: cycle-by-cycle reference model plus directed literal checks.
`timescale 1ns/1ps

module tb_board_io_ctrl;

    localparam int NK = 3;
    localparam int NL = 3;
    localparam int TD = 10;
    localparam int DB = 3;
    localparam int BL = 4;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [NK-1:0] KEY_RAW;
    logic [NK-1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE;
    logic [2*NL-1:0] LED_MODE;
    logic [8*NL-1:0] LED_DUTY;
    logic [NL-1:0] LED_OUT;
    logic          TICK;

    always #5 CLK = ~CLK;

    board_io_ctrl #(
        .NUM_KEYS(NK), .NUM_LEDS(NL), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
        .BLINK_TICKS(BL), .KEY_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .KEY_RAW(KEY_RAW), .KEY_LEVEL(KEY_LEVEL),
        .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE), .LED_MODE(LED_MODE),
        .LED_DUTY(LED_DUTY), .LED_OUT(LED_OUT), .TICK(TICK)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset release, raw key history, debounce run lengths.
    int          cyc;
    logic [NK-1:0] hist0, hist1;
    logic [NK-1:0] m_level, m_press, m_rel;
    logic        m_tick;
    logic [NL-1:0] m_led;
    int          run_len [NK];

    function automatic logic lit_for(input logic [1:0] mode, input logic [7:0] duty, input int c);
        case (mode)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return ((c / (TD * BL)) % 2) == 1;
`ifdef BOARD_IO_LED_PWM_EN
            default: return (c % 256) < int'(duty);
`else
            default: return 1'b1;
`endif
        endcase
    endfunction

    task automatic m_reset();
        cyc     = 0;
        hist0   = '0;
        hist1   = '0;
        m_level = '0;
        m_press = '0;
        m_rel   = '0;
        m_tick  = 1'b0;
        m_led   = '1;
        for (int k = 0; k < NK; k++) run_len[k] = 0;
    endtask

    task automatic m_step(input logic [NK-1:0] raw, input logic [2*NL-1:0] mode,
                          input logic [8*NL-1:0] duty);
        logic          tick_now;
        logic [NK-1:0] seen;
        tick_now = (cyc % TD) == (TD - 1);
        seen     = hist1;
        m_press  = '0;
        m_rel    = '0;
        for (int k = 0; k < NK; k++) begin
            if (seen[k] == m_level[k]) begin
                run_len[k] = 0;
            end else if (tick_now) begin
                if (run_len[k] + 1 == DB) begin
                    m_level[k] = seen[k];
                    if (seen[k]) m_press[k] = 1'b1;
                    else         m_rel[k]   = 1'b1;
                    run_len[k] = 0;
                end else begin
                    run_len[k]++;
                end
            end
        end
        for (int i = 0; i < NL; i++)
            m_led[i] = ~lit_for(mode[2*i +: 2], duty[8*i +: 8], cyc);
        hist1  = hist0;
        hist0  = ~raw;
        cyc++;
        m_tick = (cyc % TD) == (TD - 1);
    endtask

    // Compare process: model advances on each rising edge, DUT is checked on the falling edge.
    initial begin
        m_reset();
        forever begin
            @(posedge CLK);
            if (RSTN === 1'b1) m_step(KEY_RAW, LED_MODE, LED_DUTY);
            @(negedge CLK);
            if (RSTN !== 1'b1) m_reset();
            check("outputs{level,press,release,tick,led}",
                  {19'd0, KEY_LEVEL, KEY_PRESS, KEY_RELEASE, TICK, LED_OUT},
                  {19'd0, m_level, m_press, m_rel, m_tick, m_led});
        end
    end

    // Directed tallies, sampled on the falling edge.
    int cnt_tick, cnt_lit1, cnt_low2, cnt_level1;
    int cnt_press [NK];
    int cnt_rel   [NK];

    task automatic clear_tally();
        cnt_tick   = 0;
        cnt_lit1   = 0;
        cnt_low2   = 0;
        cnt_level1 = 0;
        for (int k = 0; k < NK; k++) begin
            cnt_press[k] = 0;
            cnt_rel[k]   = 0;
        end
    endtask

    task automatic tally();
        if (TICK)       cnt_tick++;
        if (!LED_OUT[1]) cnt_lit1++;
        if (!LED_OUT[2]) cnt_low2++;
        if (KEY_LEVEL[1]) cnt_level1++;
        for (int k = 0; k < NK; k++) begin
            if (KEY_PRESS[k])   cnt_press[k]++;
            if (KEY_RELEASE[k]) cnt_rel[k]++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge CLK);
            tally();
        end
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #2;
    endtask

    int lat;

    initial begin
        RSTN     = 1'b0;
        KEY_RAW  = '1;
        LED_MODE = 6'b01_01_01;
        LED_DUTY = '0;
        clear_tally();
        repeat (3) @(negedge CLK);
        check("reset_led_out", LED_OUT, 3'b111);
        check("reset_key_level", KEY_LEVEL, 3'b000);
        check("reset_tick", TICK, 1'b0);

        // Release reset with LED1 blinking: ticks on cycles 9,19..99, LED1 lit on cycles 41..80.
        drive_edge();
        RSTN     = 1'b1;
        LED_MODE = 6'b01_10_01;
        clear_tally();
        run(100);
        check("tick_count_100", cnt_tick, 10);
        check("blink_lit_cycles_100", cnt_lit1, 40);

        // Clean press on key 0.
        drive_edge();
        KEY_RAW[0] = 1'b0;
        clear_tally();
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            tally();
            if (lat < 0 && KEY_LEVEL[0]) lat = i;
        end
        check("press0_count", cnt_press[0], 1);
        check("press0_latency_in_22_42", (lat >= 22 && lat <= 42), 1'b1);
        check("level0_after_press", KEY_LEVEL[0], 1'b1);

        drive_edge();
        KEY_RAW[0] = 1'b1;
        clear_tally();
        run(60);
        check("release0_count", cnt_rel[0], 1);
        check("press0_on_release", cnt_press[0], 0);
        check("level0_after_release", KEY_LEVEL[0], 1'b0);

        // Glitch on key 1: low for 20 cycles only.
        drive_edge();
        KEY_RAW[1] = 1'b0;
        clear_tally();
        run(19);
        drive_edge();
        KEY_RAW[1] = 1'b1;
        run(40);
        check("glitch1_press_count", cnt_press[1], 0);
        check("glitch1_level_cycles", cnt_level1, 0);

        // LED2 in mode 11 with duty 64, then duty 0.
        drive_edge();
        LED_MODE = 6'b11_10_01;
        LED_DUTY = {8'd64, 8'd0, 8'd0};
        run(3);
        clear_tally();
        run(256);
`ifdef BOARD_IO_LED_PWM_EN
        check("pwm64_lit_cycles", cnt_low2, 64);
`else
        check("mode11_lit_cycles", cnt_low2, 256);
`endif
        drive_edge();
        LED_DUTY = '0;
        run(3);
        clear_tally();
        run(256);
`ifdef BOARD_IO_LED_PWM_EN
        check("pwm0_lit_cycles", cnt_low2, 0);
`else
        check("mode11_duty0_lit_cycles", cnt_low2, 256);
`endif

        // Randomised keys, modes and duties against the model.
        repeat (60) begin
            drive_edge();
            KEY_RAW  = NK'($urandom);
            LED_MODE = (2*NL)'($urandom);
            LED_DUTY = (8*NL)'($urandom);
            run($urandom_range(1, 70));
        end

        // Reset mid-debounce on key 2.
        drive_edge();
        KEY_RAW  = '1;
        LED_MODE = 6'b01_01_01;
        run(80);
        drive_edge();
        KEY_RAW[2] = 1'b0;
        clear_tally();
        run(20);
        check("press2_before_reset", cnt_press[2], 0);
        drive_edge();
        RSTN = 1'b0;
        run(3);
        check("reset_mid_level2", KEY_LEVEL[2], 1'b0);
        drive_edge();
        RSTN = 1'b1;
        clear_tally();
        run(40);
        check("press2_after_reset_count", cnt_press[2], 1);
        check("level2_after_reset", KEY_LEVEL[2], 1'b1);

        drive_edge();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board I/O controller between FPGA pins and SoC GPIO. Debounces NUM_KEYS push-buttons into clean levels plus one-cycle press/release events, and drives NUM_LEDS LEDs in off/on/blink/PWM modes from a shared timebase. Sits in the board top level next to the SoC wrapper, replacing direct pin-to-GPIO wiring for keys and LEDs.

## Interface
- NUM_KEYS, 3, number of key inputs (1..16)
- NUM_LEDS, 3, number of LED outputs (1..16)
- TICK_DIV, 50000, CLK cycles per timebase tick (≥2; 1 ms at 50 MHz)
- DEBOUNCE_TICKS, 20, ticks a changed key level must persist before acceptance (≥1)
- BLINK_TICKS, 250, ticks per blink half-period (≥1)
- KEY_ACTIVE_LOW, 1, raw key pin reads 0 when pressed
- LED_ACTIVE_LOW, 1, LED pin driven 0 to light
- CLK  in  1  system clock; all logic on rising edge
- RSTN  in  1  asynchronous active-low reset
- KEY_RAW  in  NUM_KEYS  raw key pins, asynchronous
- KEY_LEVEL  out  NUM_KEYS  debounced logical state, 1 = pressed
- KEY_PRESS  out  NUM_KEYS  1-cycle pulse on accepted press
- KEY_RELEASE  out  NUM_KEYS  1-cycle pulse on accepted release
- LED_MODE  in  2*NUM_LEDS  per-LED mode, LED i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM
- LED_DUTY  in  8*NUM_LEDS  per-LED PWM duty, LED i at [8i+7:8i]
- LED_OUT  out  NUM_LEDS  LED pins, polarity per LED_ACTIVE_LOW
- TICK  out  1  1-cycle timebase pulse, exported for software timers

## Operation
- Timebase: counter 0..TICK_DIV-1, increments every CLK; TICK high in the cycle the counter equals TICK_DIV-1, then counter wraps to 0.
- Key path per channel: 2-FF synchroniser, then invert if KEY_ACTIVE_LOW to logical pressed; synchroniser flops reset to the released level.
- Debounce per channel: if synced ≠ KEY_LEVEL, counter increments on each TICK; if synced = KEY_LEVEL in any cycle, counter clears to 0. When counter reaches DEBOUNCE_TICKS on a TICK, KEY_LEVEL takes synced value, counter clears, and KEY_PRESS (0→1) or KEY_RELEASE (1→0) pulses in the same cycle KEY_LEVEL changes.
- Glitch shorter than DEBOUNCE_TICKS ticks: no level change, no event.
- Blink: shared tick counter 0..BLINK_TICKS-1; blink phase toggles on the TICK where counter wraps; phase resets to 0 (dark).
- PWM: shared 8-bit free-running counter, +1 every CLK, wraps 255→0. PWM LED lit when counter < duty: duty 0 never lit, 255 lit 255/256 cycles.
- LED_OUT registered: lit = mode-selected value; pin = lit XOR LED_ACTIVE_LOW.
- Mode or duty change takes effect from the next CLK; no glitch suppression on mode change.

## Timing
- Reset: KEY_LEVEL 0, KEY_PRESS 0, KEY_RELEASE 0, TICK 0, LED_OUT = unlit level (all 1s when LED_ACTIVE_LOW), all counters 0.
- KEY_RAW edge to KEY_LEVEL/event: 2 CLK sync + DEBOUNCE_TICKS ticks (+ up to TICK_DIV cycles to the first tick).
- Key held through reset release: treated as a fresh press; KEY_PRESS fires after debounce.
- Reset asserted mid-debounce: counter cleared, no event emitted.
- LED_MODE/LED_DUTY to LED_OUT: 1 CLK.
- Simultaneous events across channels are independent; several KEY_PRESS bits may pulse in one cycle.
- TICK and all outputs glitch-free (flop outputs).

## Configuration
- BOARD_IO_LED_PWM_EN defined: PWM counter and per-LED comparators built; mode 11 is PWM per LED_DUTY.
- Undefined: no PWM counter, LED_DUTY ignored; mode 11 behaves as mode 01 (on).

## Test plan
Params for all: TICK_DIV=10, DEBOUNCE_TICKS=3, BLINK_TICKS=4, NUM_KEYS=3, NUM_LEDS=3, both active-low.
- Reset: RSTN low with LED_MODE all 01 -> LED_OUT=3'b111, KEY_LEVEL=0, TICK=0; after release TICK pulses every 10 cycles.
- Clean press: KEY_RAW[0] 1→0 held 60 cycles -> KEY_PRESS[0] one pulse, KEY_LEVEL[0]=1 within 2+3 ticks (≤42 cycles); then 1 -> KEY_RELEASE[0] one pulse.
- Glitch: KEY_RAW[1] low for 2 ticks (20 cycles) then high -> no KEY_PRESS[1], KEY_LEVEL[1] stays 0.
- Blink: LED_MODE[3:2]=10 -> LED_OUT[1] toggles every 40 cycles, starting dark after reset.
- PWM (macro defined): LED_DUTY[23:16]=64, mode 11 -> LED_OUT[2] low exactly 64 of every 256 cycles; duty 0 -> always high. Macro undefined: mode 11 -> constant low.
- Reset mid-debounce: KEY_RAW[2] low, RSTN pulsed after 2 ticks -> no KEY_PRESS[2] before reset; press emitted 3 ticks after reset release if still held.
